// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction-memory request/ack bus between fetch stage and memory
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: PC, imem req/ack, IF/ID register
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    if_stage_if.master  imem,
    output logic [31:0] cmd,
    output logic [31:0] PCPlusFourD,
    output logic        validD,
    output logic [1:0]  if_state
);
    typedef enum logic [1:0] {FETCH = 2'd0, DISCARD = 2'd1, HOLD = 2'd2} state_t;

    state_t      r_state, w_state;
    logic        r_started;
    logic [31:0] r_pc, w_pc;
    logic [31:0] r_disc_addr, w_disc_addr;
    logic [31:0] r_cmd, w_cmd;
    logic [31:0] r_pc4, w_pc4;
    logic        r_valid, w_valid;
    logic [31:0] r_skid_cmd, w_skid_cmd;
    logic [31:0] r_skid_pc4, w_skid_pc4;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_xfer;
    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FETCH;
            r_started   <= 1'b0;
            r_pc        <= RESET_PC;
            r_disc_addr <= 32'h0;
            r_cmd       <= NOP_WORD;
            r_pc4       <= 32'h0;
            r_valid     <= 1'b0;
            r_skid_cmd  <= NOP_WORD;
            r_skid_pc4  <= 32'h0;
        end else begin
            r_state     <= w_state;
            r_started   <= 1'b1;
            r_pc        <= w_pc;
            r_disc_addr <= w_disc_addr;
            r_cmd       <= w_cmd;
            r_pc4       <= w_pc4;
            r_valid     <= w_valid;
            r_skid_cmd  <= w_skid_cmd;
            r_skid_pc4  <= w_skid_pc4;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_pc        = r_pc;
        w_disc_addr = r_disc_addr;
        w_cmd       = r_cmd;
        w_pc4       = r_pc4;
        w_valid     = r_valid;
        w_skid_cmd  = r_skid_cmd;
        w_skid_pc4  = r_skid_pc4;

        // DISCARD keeps presenting the wrong-path address until memory completes it
        w_req      = r_started && (r_state != HOLD);
        w_addr     = (r_state == DISCARD) ? r_disc_addr : (r_pc & ~32'h3);
        w_xfer     = w_req && imem.imem_ack;
        w_redirect = PCSrcD && !StallD && r_valid;
        w_target   = PCBranchD & ~32'h3;
        w_pc_inc   = r_pc + 32'd4;

        case (r_state)
            FETCH: begin
                if (w_redirect) begin
                    w_pc    = w_target;
                    w_cmd   = NOP_WORD;
                    w_valid = 1'b0;
                    if (!w_xfer) begin
                        w_disc_addr = w_addr;
                        w_state     = DISCARD;
                    end
                end else if (w_xfer) begin
                    w_pc = w_pc_inc;
                    if (!StallD) begin
                        w_cmd   = imem.imem_rdata;
                        w_pc4   = w_pc_inc;
                        w_valid = 1'b1;
                    end else begin
                        w_skid_cmd = imem.imem_rdata;
                        w_skid_pc4 = w_pc_inc;
                        w_state    = HOLD;
                    end
                end else if (!StallD) begin
                    w_cmd   = NOP_WORD;
                    w_valid = 1'b0;
                end
            end
            DISCARD: begin
                if (w_xfer) w_state = FETCH;
            end
            HOLD: begin
                if (!StallD) begin
                    w_state = FETCH;
                    if (w_redirect) begin
                        w_pc    = w_target;
                        w_cmd   = NOP_WORD;
                        w_valid = 1'b0;
                    end else begin
                        w_cmd   = r_skid_cmd;
                        w_pc4   = r_skid_pc4;
                        w_valid = 1'b1;
                    end
                end
            end
            default: w_state = FETCH;
        endcase
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = w_addr;
    assign cmd            = r_cmd;
    assign PCPlusFourD    = r_pc4;
    assign validD         = r_valid;
    assign if_state       = r_state;
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage with a variable-latency memory model
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallD;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic [31:0] cmd;
    logic [31:0] PCPlusFourD;
    logic        validD;
    logic [1:0]  if_state;

    if_stage_if bus ();

    if_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .StallD     (StallD),
        .PCSrcD     (PCSrcD),
        .PCBranchD  (PCBranchD),
        .imem       (bus.master),
        .cmd        (cmd),
        .PCPlusFourD(PCPlusFourD),
        .validD     (validD),
        .if_state   (if_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   lat   = 0;
    int   r_wait;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h2008_0005;
            32'h0000_0004: mem_word = 32'h2009_0003;
            default:       mem_word = a ^ 32'hC000_0000;
        endcase
    endfunction

    // Memory: acks once the request has waited lat cycles; drops it on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          r_wait <= 0;
        else if (bus.imem_req && bus.imem_ack) r_wait <= 0;
        else if (bus.imem_req)               r_wait <= r_wait + 1;
    end
    assign bus.imem_ack   = bus.imem_req && (r_wait >= lat);
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void push(input logic [31:0] w, input logic [31:0] p);
        exp_q.push_back({w, p});
    endfunction

    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    // Monitor: pops one entry per instruction decode consumes, and checks request stability
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pend = 1'b0;
        end else begin
            if (prev_pend) begin
                chk("req_held", {31'h0, bus.imem_req}, 32'h1);
                chk("addr_held", bus.imem_addr, prev_addr);
            end
            prev_pend = bus.imem_req && !bus.imem_ack;
            prev_addr = bus.imem_addr;
            if (validD && !StallD) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_instr: got %h want none", cmd);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_cmd", cmd, e.word);
                    chk("sb_pc4", PCPlusFourD, e.pc4);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; PCBranchD = 32'h0; lat = 0;
        tick(); tick();
        chk("rst_cmd", cmd, 32'h0);
        chk("rst_pc4", PCPlusFourD, 32'h0);
        chk("rst_valid", {31'h0, validD}, 32'h0);
        chk("rst_state", {30'h0, if_state}, 32'h0);
        chk("rst_req", {31'h0, bus.imem_req}, 32'h0);

        push(32'h2008_0005, 32'h4);
        push(32'h2009_0003, 32'h8);
        push(32'hC000_0008, 32'hC);
        rst_n = 1'b1;
        #1 chk("req_after_release", {31'h0, bus.imem_req}, 32'h0);
        tick();                                  // E1: request rises
        #3 chk("first_req", {31'h0, bus.imem_req}, 32'h1);
        chk("first_addr", bus.imem_addr, 32'h0);
        tick();                                  // E2
        tick();                                  // E3
        lat = 3;
        #3 chk("slow_addr0", bus.imem_addr, 32'h8);
        tick();                                  // E4: bubble
        #3 chk("bubble_valid", {31'h0, validD}, 32'h0);
        chk("slow_addr1", bus.imem_addr, 32'h8);
        tick(); tick();                          // E5, E6
        #3 chk("slow_addr3", bus.imem_addr, 32'h8);
        tick();                                  // E7
        push(32'hC000_000C, 32'h10);
        #3 chk("addr_c", bus.imem_addr, 32'hC);
        tick(); tick(); tick();                  // E8..E10
        StallD = 1'b1;
        tick();                                  // E11: ack under stall
        #3 chk("hold_state", {30'h0, if_state}, 32'h2);
        chk("hold_req", {31'h0, bus.imem_req}, 32'h0);
        tick();                                  // E12
        #3 chk("hold_cmd", cmd, 32'h0);
        chk("hold_valid", {31'h0, validD}, 32'h0);
        tick(); tick();                          // E13, E14
        StallD = 1'b0;
        tick();                                  // E15: buffer into IF/ID
        PCSrcD = 1'b1; PCBranchD = 32'h40;
        #3 chk("after_hold_addr", bus.imem_addr, 32'h10);
        tick();                                  // E16: redirect, fetch in flight
        PCSrcD = 1'b0;
        #3 chk("disc_state", {30'h0, if_state}, 32'h1);
        chk("disc_addr", bus.imem_addr, 32'h10);
        chk("disc_cmd", cmd, 32'h0);
        chk("disc_valid", {31'h0, validD}, 32'h0);
        tick(); tick(); tick();                  // E17..E19
        lat = 0;
        push(32'hC000_0040, 32'h44);
        #3 chk("target_addr", bus.imem_addr, 32'h40);
        chk("target_state", {30'h0, if_state}, 32'h0);
        tick();                                  // E20
        StallD = 1'b1; PCSrcD = 1'b1; PCBranchD = 32'h80;
        tick();                                  // E21: stalled redirect ignored
        #3 chk("hold2_state", {30'h0, if_state}, 32'h2);
        chk("hold2_cmd", cmd, 32'hC000_0040);
        tick();                                  // E22
        StallD = 1'b0; PCBranchD = 32'h100;
        push(32'hC000_0100, 32'h104);
        tick();                                  // E23: redirect out of HOLD
        PCSrcD = 1'b0;
        #3 chk("hold_redir_addr", bus.imem_addr, 32'h100);
        chk("hold_redir_valid", {31'h0, validD}, 32'h0);
        tick();                                  // E24
        PCSrcD = 1'b1; PCBranchD = 32'hFFFF_FFFC;
        push(32'h3FFF_FFFC, 32'h0);
        tick();                                  // E25: redirect with transfer
        PCSrcD = 1'b0;
        #3 chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_flush_valid", {31'h0, validD}, 32'h0);
        tick();                                  // E26
        lat = 3;
        #3 chk("wrap_next_addr", bus.imem_addr, 32'h0);
        chk("wrap_pc4", PCPlusFourD, 32'h0);
        tick();                                  // E27
        rst_n = 1'b0;
        #1 chk("midrst_req", {31'h0, bus.imem_req}, 32'h0);
        chk("midrst_cmd", cmd, 32'h0);
        chk("midrst_valid", {31'h0, validD}, 32'h0);
        chk("midrst_state", {30'h0, if_state}, 32'h0);
        push(32'h2008_0005, 32'h4);
        tick();                                  // E28
        rst_n = 1'b1; lat = 0;
        tick();                                  // E29
        #3 chk("restart_addr", bus.imem_addr, 32'h0);
        chk("restart_req", {31'h0, bus.imem_req}, 32'h1);
        tick();                                  // E30
        tick();                                  // E31
        StallD = 1'b1;
        tick(); tick();
        chk("sb_drained", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS CPU, directly upstream of the decode stage.
- Owns the program counter and issues requests to instruction memory over a req/ack handshake that tolerates variable latency.
- Drives the IF/ID pipeline register: `cmd` and `PCPlusFourD` feed decode.
- Handles decode stalls, taken-branch/jump redirects from decode, and fetches that are still in flight when a redirect arrives.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_WORD, 32'h00000000, word placed in `cmd` on reset or flush (SLL $0,$0,0).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- StallD  in  1  hazard unit holds the IF/ID register and PC.
- PCSrcD  in  1  decode requests a redirect (taken BEQ/BNE, JAL, JR).
- PCBranchD  in  32  redirect target from decode.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; bits [1:0] always 0.
- imem_ack  in  1  memory returns data this cycle; valid only while imem_req=1.
- imem_rdata  in  32  instruction word, sampled when imem_req&imem_ack.
- cmd  out  32  instruction presented to decode (IF/ID register).
- PCPlusFourD  out  32  PC of `cmd` plus 4 (IF/ID register).
- validD  out  1  `cmd` holds a real fetched instruction.
- if_state  out  2  FSM state, for debug and verification.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - PCF=RESET_PC, state=FETCH, cmd=NOP_WORD, PCPlusFourD=0, validD=0.
  - imem_req=0 while rst_n=0; it rises on the first clock edge after release.
- States: FETCH=0, DISCARD=1, HOLD=2.
- imem_addr = {PCF[31:2],2'b00}; PCBranchD[1:0] is ignored.
- Handshake rules:
  - Once raised, imem_req stays high with imem_addr constant until imem_ack.
  - A request is never withdrawn.
  - Zero-wait memory is legal: ack may arrive in the same cycle req rises.
- Transfer = imem_req & imem_ack at a clock edge.
- Redirect is valid only when PCSrcD=1, StallD=0 and validD=1. PCSrcD is ignored while StallD=1.
- FETCH (imem_req=1):
  - Redirect + transfer: drop rdata; PCF<=PCBranchD; cmd<=NOP_WORD; validD<=0; stay in FETCH.
  - Redirect, no transfer: PCF<=PCBranchD; flush IF/ID; go to DISCARD.
  - Transfer, StallD=0: cmd<=rdata; PCPlusFourD<=PCF+4; validD<=1; PCF<=PCF+4; stay in FETCH (back-to-back fetch, 1 instruction/cycle with zero-wait memory).
  - Transfer, StallD=1: capture rdata and PCF+4 in a one-entry skid buffer; PCF<=PCF+4; go to HOLD.
  - No transfer, StallD=0: validD<=0 and cmd<=NOP_WORD (bubble into decode).
- DISCARD (imem_req=1, imem_addr = old address latched at the redirect):
  - Keep requesting until transfer, then drop the data and go to FETCH at the new PCF.
  - No further redirect can occur here, since validD=0.
- HOLD (imem_req=0):
  - While StallD=1, IF/ID and the buffer are held.
  - When StallD=0 and there is no redirect: buffer moves to IF/ID (validD<=1); go to FETCH.
  - When StallD=0 with a redirect: discard the buffer; PCF<=PCBranchD; flush IF/ID; go to FETCH.
- While StallD=1, IF/ID (cmd, PCPlusFourD, validD) never changes.
- PC arithmetic is modulo 2^32: 32'hFFFFFFFC+4 = 32'h00000000.
- Reset asserted mid-fetch abandons the outstanding request; memory must drop it on reset.
- No instruction is ever delivered twice or skipped, except for the wrong-path fetch after a redirect.

Test Plan:
- Zero-wait memory, imem[0]=0x20080005, imem[4]=0x20090003: after reset, cmd=0x20080005 with PCPlusFourD=4, then cmd=0x20090003 with PCPlusFourD=8 on consecutive cycles; validD=1 from the first fetch onward.
- 3-cycle ack latency: imem_addr is held at 0x8 for 3 cycles with imem_req=1; validD=0 bubbles appear between instructions; no request is dropped.
- Redirect with a fetch in flight: PCSrcD=1, PCBranchD=0x40, issued while the fetch of 0x10 is still unacknowledged → if_state=DISCARD; the 0x10 data is never seen on cmd; the next request address is 0x40; IF/ID shows NOP_WORD, validD=0.
- StallD=1 for 4 cycles when the ack of 0xC arrives: cmd frozen, if_state=HOLD, imem_req=0; after release, cmd=imem[0xC], PCPlusFourD=0x10, and the next request is to 0x10.
- StallD=1 and PCSrcD=1 together: no redirect. Then StallD=0 with PCSrcD=1, target 0x100, while in HOLD: buffered word discarded; the next fetch is at 0x100.
- Wrap and reset: with PCF=0xFFFFFFFC, the next address is 0x0. rst_n pulsed low mid-request → imem_req=0, cmd=0, validD=0 immediately; after release, the fetch restarts at RESET_PC.
